// File: rtl/prog_clk_div.sv
// rtl/prog_clk_div.sv - multi-channel programmable divider with shadowed config
// Each channel: N-cycle period, low N-H then high H; config applied only at period boundaries.
module prog_clk_div #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int DEF_DIV  = 64,
  parameter int DEF_HIGH = 32,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] en_i,
  input  logic                cfg_we_i,
  input  logic [CH_W-1:0]     cfg_ch_i,
  input  logic [WIDTH-1:0]    cfg_div_i,
  input  logic [WIDTH-1:0]    cfg_high_i,
  output logic [CHANNELS-1:0] div_o,
  output logic [CHANNELS-1:0] tick_o,
  output logic [CHANNELS-1:0] pend_o
);

  localparam logic [CH_W:0]    CH_LIM = (CH_W + 1)'(CHANNELS);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic ch_valid;
  assign ch_valid = ({1'b0, cfg_ch_i} < CH_LIM);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(c);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_q, n_d, h_q, h_d;
    logic [WIDTH-1:0] sn_q, sn_d, sh_q, sh_d;
    logic             div_q, div_d, tick_q, tick_d, pend_q, pend_d;
    logic [WIDTH-1:0] thr;
    logic             wr, parked, wrap, apply;

    always_comb begin
      wr     = cfg_we_i && ch_valid && (cfg_ch_i == IDX);
      parked = (n_q == '0);
      wrap   = (cnt_q == n_q - ONE);
      thr    = (h_q >= n_q) ? '0 : n_q - h_q;
      // A period boundary is the wrap edge, or any edge where nothing is mid-count.
      apply  = pend_q && (parked || !en_i[c] || wrap);

      cnt_d  = cnt_q;
      n_d    = n_q;
      h_d    = h_q;
      sn_d   = sn_q;
      sh_d   = sh_q;
      div_d  = div_q;
      tick_d = 1'b0;
      pend_d = pend_q;

      if (parked) begin
        cnt_d = '0;
        div_d = 1'b0;
      end else if (en_i[c]) begin
        div_d  = (cnt_q >= thr);
        tick_d = (cnt_q == '0);
        cnt_d  = wrap ? '0 : cnt_q + ONE;
      end

      if (apply) begin
        n_d    = sn_q;
        h_d    = sh_q;
        cnt_d  = '0;
        pend_d = 1'b0;
      end

      // A write on the apply edge lands after the copy, so it waits for the next boundary.
      if (wr) begin
        sn_d   = cfg_div_i;
        sh_d   = cfg_high_i;
        pend_d = 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q  <= '0;
        n_q    <= WIDTH'(DEF_DIV);
        h_q    <= WIDTH'(DEF_HIGH);
        sn_q   <= WIDTH'(DEF_DIV);
        sh_q   <= WIDTH'(DEF_HIGH);
        div_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        n_q    <= n_d;
        h_q    <= h_d;
        sn_q   <= sn_d;
        sh_q   <= sh_d;
        div_q  <= div_d;
        tick_q <= tick_d;
        pend_q <= pend_d;
      end
    end

    assign div_o[c]  = div_q;
    assign tick_o[c] = tick_q;
    assign pend_o[c] = pend_q;
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// tb/tb_prog_clk_div.sv - directed and randomized bench for prog_clk_div
// Expected values come from constants and a period-position reference model.
module tb_prog_clk_div;
  localparam int NCH = 5;
  localparam int W   = 16;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           we;
  logic [CW-1:0]  ch;
  logic [W-1:0]   cdiv, chigh;
  logic [NCH-1:0] div_o, tick_o, pend_o;

  int checks = 0;
  int failures = 0;

  int m_cnt[NCH], m_n[NCH], m_h[NCH], m_sn[NCH], m_sh[NCH];
  bit m_div[NCH], m_tick[NCH], m_pend[NCH];

  prog_clk_div #(.CHANNELS(NCH), .WIDTH(W), .DEF_DIV(64), .DEF_HIGH(32)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .cfg_we_i(we), .cfg_ch_i(ch),
    .cfg_div_i(cdiv), .cfg_high_i(chigh),
    .div_o(div_o), .tick_o(tick_o), .pend_o(pend_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_n[c] = 64; m_h[c] = 32; m_sn[c] = 64; m_sh[c] = 32;
      m_div[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
    end
  endtask

  // Position-in-period model: output high once position reaches N-H (always if H>=N).
  task automatic model_edge();
    bit at_end;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      at_end = (m_n[c] == 0) || !en[c] || (m_cnt[c] == m_n[c] - 1);
      if (m_n[c] == 0) begin
        m_div[c] = 0; m_tick[c] = 0; m_cnt[c] = 0;
      end else if (en[c]) begin
        m_div[c]  = (m_cnt[c] >= m_n[c] - m_h[c]);
        m_tick[c] = (m_cnt[c] == 0);
        m_cnt[c]  = (m_cnt[c] + 1) % m_n[c];
      end else begin
        m_tick[c] = 0;
      end
      if (m_pend[c] && at_end) begin
        m_n[c] = m_sn[c]; m_h[c] = m_sh[c]; m_cnt[c] = 0; m_pend[c] = 0;
      end
      if (we && int'(ch) == c) begin
        m_sn[c] = int'(cdiv); m_sh[c] = int'(chigh); m_pend[c] = 1;
      end
    end
  endtask

  function automatic logic [NCH-1:0] exp_vec(input int sel);
    logic [NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++)
      v[c] = (sel == 0) ? m_div[c] : (sel == 1) ? m_tick[c] : m_pend[c];
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_div"},  32'(div_o),  32'(exp_vec(0)));
    chk({tag, "_tick"}, 32'(tick_o), 32'(exp_vec(1)));
    chk({tag, "_pend"}, 32'(pend_o), 32'(exp_vec(2)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all("model");
  endtask

  task automatic wr(input int c, input int n, input int h);
    we = 1'b1; ch = CW'(c); cdiv = W'(n); chigh = W'(h);
    step();
    we = 1'b0;
  endtask

  initial begin
    int d0[140], t0[140];
    int first, second, low, high, n;
    int pat2[5];
    int pat4[4];
    pat2 = '{0, 0, 0, 1, 1};
    pat4 = '{0, 0, 0, 1};

    rst = 1'b1; en = '0; we = 1'b0; ch = '0; cdiv = '0; chigh = '0;
    model_reset();
    repeat (2) step();
    chk("rst_div",  32'(div_o),  32'(0));
    chk("rst_tick", 32'(tick_o), 32'(0));
    chk("rst_pend", 32'(pend_o), 32'(0));
    rst = 1'b0;

    // default 64-cycle, 50% duty on channel 0
    en = 5'b00001;
    for (int i = 0; i < 140; i++) begin
      step();
      d0[i] = int'(div_o[0]);
      t0[i] = int'(tick_o[0]);
    end
    first = -1; second = -1;
    for (int i = 0; i < 140; i++)
      if (t0[i] == 1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    chk("t1_period", 32'(second - first), 32'(64));
    low = 0; high = 0;
    if (first >= 0) begin
      for (int i = first; i < 140 && d0[i] == 0; i++) low++;
      for (int i = first + low; i < 140 && d0[i] == 1; i++) high++;
    end
    chk("t1_low", 32'(low), 32'(32));
    chk("t1_high", 32'(high), 32'(32));
    chk("t1_pend", 32'(pend_o), 32'(0));

    // channel 1: reconfigure at cnt=10, old period must finish first
    en = 5'b00011;
    repeat (10) step();
    wr(1, 5, 2);
    chk("t2_pend_set", 32'(pend_o[1]), 32'(1));
    n = 0;
    while (pend_o[1] && n < 100) begin step(); n++; end
    chk("t2_apply_edges", 32'(n), 32'(53));
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_div", 32'(div_o[1]), 32'(pat2[i % 5]));
      chk("t2_tick", 32'(tick_o[1]), 32'((i % 5) == 0));
    end

    // channel 2: H>=N gives constant 1, then N=1 H=0 gives constant 0 with tick every cycle
    en = 5'b00111;
    wr(2, 3, 7);
    n = 0;
    while (pend_o[2] && n < 100) begin step(); n++; end
    chk("t3_apply_a", 32'(pend_o[2]), 32'(0));
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t3_const1", 32'(div_o[2]), 32'(1));
    end
    wr(2, 1, 0);
    n = 0;
    while (pend_o[2] && n < 10) begin step(); n++; end
    chk("t3_apply_b", 32'(pend_o[2]), 32'(0));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_const0", 32'(div_o[2]), 32'(0));
      chk("t3_tick_all", 32'(tick_o[2]), 32'(1));
    end

    // channel 3: park with N=0, then restart with N=4 H=1; out-of-range writes ignored
    wr(3, 0, 0);
    step();
    chk("t4_park_apply", 32'(pend_o[3]), 32'(0));
    en = 5'b01111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_park_div", 32'(div_o[3]), 32'(0));
      chk("t4_park_tick", 32'(tick_o[3]), 32'(0));
    end
    wr(3, 4, 1);
    chk("t4_pend", 32'(pend_o[3]), 32'(1));
    step();
    chk("t4_apply_next", 32'(pend_o[3]), 32'(0));
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t4_div", 32'(div_o[3]), 32'(pat4[i % 4]));
      chk("t4_tick", 32'(tick_o[3]), 32'((i % 4) == 0));
    end
    wr(5, 2, 1);
    wr(7, 2, 1);
    chk("t4_oob_pend", 32'(pend_o), 32'(0));
    repeat (3) step();

    // channel 0: pause 7 cycles in the high phase, period stretches by 7
    n = 0;
    while (!tick_o[0] && n < 100) begin step(); n++; end
    chk("t5_found_tick", 32'(tick_o[0]), 32'(1));
    repeat (39) step();
    en[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t5_hold_div", 32'(div_o[0]), 32'(1));
      chk("t5_hold_tick", 32'(tick_o[0]), 32'(0));
    end
    en[0] = 1'b1;
    n = 0;
    do begin step(); n++; end while (!tick_o[0] && n < 100);
    chk("t5_elapsed", 32'(39 + 7 + n), 32'(71));

    // async reset mid-period with a pending write
    wr(0, 10, 5);
    chk("t6_pend_set", 32'(pend_o[0]), 32'(1));
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_async_div", 32'(div_o), 32'(0));
    chk("t6_async_tick", 32'(tick_o), 32'(0));
    chk("t6_async_pend", 32'(pend_o), 32'(0));
    step();
    rst = 1'b0;
    en = 5'b00001;
    step();
    chk("t6_first_tick", 32'(tick_o[0]), 32'(1));
    repeat (63) step();
    chk("t6_default_period", 32'(tick_o[0]), 32'(0));
    step();
    chk("t6_next_tick", 32'(tick_o[0]), 32'(1));

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      en    = NCH'($urandom_range(0, 31) | $urandom_range(0, 31));
      we    = ($urandom_range(0, 3) == 0);
      ch    = CW'($urandom_range(0, 7));
      cdiv  = W'($urandom_range(0, 9));
      chigh = W'($urandom_range(0, 10));
      step();
    end
    we = 1'b0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
